tdm_demux4: RTL

- Receive-side partner of the team's 4-channel, 4-bit selector.
- Accepts a time-division-multiplexed stream: one WIDTH-bit word per valid cycle, four slots per frame, slot 0 flagged by Sync.
- Deserializes the stream back into four parallel channel registers (A, B, C, D), updated atomically once per complete frame.
- Detects framing errors and re-acquires frame lock.

---
 rtl/tdm_demux4.sv | 100 ++++++++++
 1 files changed

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - 4-slot TDM deserializer with sync-based frame lock
// Slots 0..2 collect in shadow registers; the slot-3 word commits all four channels at once.
module tdm_demux4 #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [WIDTH-1:0] Din,
  input  logic             Din_valid,
  input  logic             Sync,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic             Frame_valid,
  output logic             Locked,
  output logic             Sync_err,
  output logic [1:0]       Slot,
  output logic [CNT_W-1:0] Frame_cnt
);

  typedef enum logic {HUNT = 1'b0, LOCKED = 1'b1} state_t;

  state_t           state;
  logic [WIDTH-1:0] s0, s1, s2;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= HUNT;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      A           <= '0;
      B           <= '0;
      C           <= '0;
      D           <= '0;
      Frame_valid <= 1'b0;
      Sync_err    <= 1'b0;
      Locked      <= 1'b0;
      Slot        <= 2'd0;
      Frame_cnt   <= '0;
    end else begin
      Frame_valid <= 1'b0;
      Sync_err    <= 1'b0;
      if (Din_valid) begin
        case (state)
          HUNT: begin
            if (Sync) begin
              s0     <= Din;
              Slot   <= 2'd1;
              state  <= LOCKED;
              Locked <= 1'b1;
            end
          end
          LOCKED: begin
            if (Slot == 2'd0) begin
              if (Sync) begin
                s0   <= Din;
                Slot <= 2'd1;
              end else begin
                Sync_err <= 1'b1;
                state    <= HUNT;
                Locked   <= 1'b0;
                Slot     <= 2'd0;
              end
            end else if (Sync) begin
              // Early sync: restart the frame on this word rather than losing lock.
              Sync_err <= 1'b1;
              s0       <= Din;
              Slot     <= 2'd1;
            end else begin
              case (Slot)
                2'd1: begin
                  s1   <= Din;
                  Slot <= 2'd2;
                end
                2'd2: begin
                  s2   <= Din;
                  Slot <= 2'd3;
                end
                default: begin
                  A           <= s0;
                  B           <= s1;
                  C           <= s2;
                  D           <= Din;
                  Frame_valid <= 1'b1;
                  Frame_cnt   <= Frame_cnt + 1'b1;
                  Slot        <= 2'd0;
                end
              endcase
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule
